// File: rtl/lsu_wb_stage_if.sv
// lsu_wb_stage_if: execute-stage handshake, data-memory request and
// register-file write port of the load/store + writeback stage.
// master = the stage itself, slave = its surroundings (execute, memory, RF).
interface lsu_wb_stage_if;
    localparam int unsigned XLEN = 32;

    // execute stage -> stage
    logic              ex_valid;
    logic              ex_ready;
    logic [XLEN-1:0]   ex_alu_result;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_store_data;
    logic [4:0]        ex_rd;
    logic [1:0]        ex_wb_sel;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic [2:0]        ex_funct3;

    // data-memory request
    logic              mem_req;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ack;
    logic [XLEN-1:0]   mem_rdata;

    // register-file write port
    logic              rf_en;
    logic [4:0]        rf_rd;
    logic [XLEN-1:0]   rf_wdata;
    logic              misalign;

    modport master (
        input  ex_valid, ex_alu_result, ex_pc, ex_store_data, ex_rd,
               ex_wb_sel, ex_mem_read, ex_mem_write, ex_funct3,
               mem_ack, mem_rdata,
        output ex_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
               rf_en, rf_rd, rf_wdata, misalign
    );

    modport slave (
        output ex_valid, ex_alu_result, ex_pc, ex_store_data, ex_rd,
               ex_wb_sel, ex_mem_read, ex_mem_write, ex_funct3,
               mem_ack, mem_rdata,
        input  ex_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
               rf_en, rf_rd, rf_wdata, misalign
    );
endinterface

// File: rtl/lsu_wb_stage.sv
// lsu_wb_stage: final RV32I pipeline stage. Accepts one executed instruction
// per handshake, performs loads/stores over a single-request memory
// handshake and drives the registered register-file write port.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses are not
// issued and raise a one-cycle misalign pulse instead of being force-aligned.
module lsu_wb_stage (
    input  logic                 clk,
    input  logic                 rst,
    lsu_wb_stage_if.master       bus
);
    localparam int unsigned XLEN = 32;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam logic [1:0] WB_PC4  = 2'b10;
    localparam logic [1:0] WB_NONE = 2'b11;

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [4:0]        rd_q, rd_d;
    logic              rf_en_q, rf_en_d;
    logic [4:0]        rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
    logic              misalign_q, misalign_d;

    logic              accept_c;
    logic              is_byte_c;
    logic              is_half_c;
    logic              trap_c;
    logic [1:0]        eff_off_c;
    logic [XLEN-1:0]   st_rep_c;
    logic [3:0]        st_strb_c;
    logic [XLEN-1:0]   ld_shift_c;
    logic [XLEN-1:0]   ld_val_c;

    assign accept_c     = bus.ex_valid && (state_q == IDLE);
    assign bus.ex_ready = (state_q == IDLE);

    // Decode access size, effective lane offset and the misalignment condition
    always_comb begin
        is_byte_c = (bus.ex_funct3[1:0] == 2'b00);
        is_half_c = (bus.ex_funct3[1:0] == 2'b01);
        if (is_byte_c) begin
            eff_off_c = bus.ex_alu_result[1:0];
        end else if (is_half_c) begin
            eff_off_c = {bus.ex_alu_result[1], 1'b0};
        end else begin
            eff_off_c = 2'b00;
        end
`ifdef LSU_MISALIGN_TRAP_EN
        trap_c = (is_half_c && bus.ex_alu_result[0])
              || (!is_byte_c && !is_half_c && (bus.ex_alu_result[1:0] != 2'b00));
`else
        trap_c = 1'b0;
`endif
    end

    // Replicate store data across lanes and build the byte strobes
    always_comb begin
        if (is_byte_c) begin
            st_rep_c  = {4{bus.ex_store_data[7:0]}};
            st_strb_c = 4'(4'b0001 << eff_off_c);
        end else if (is_half_c) begin
            st_rep_c  = {2{bus.ex_store_data[15:0]}};
            st_strb_c = 4'(4'b0011 << eff_off_c);
        end else begin
            st_rep_c  = bus.ex_store_data;
            st_strb_c = 4'b1111;
        end
    end

    // Extract the addressed lane of the read word and sign/zero extend it
    always_comb begin
        ld_shift_c = bus.mem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  ld_val_c = {{24{ld_shift_c[7]}}, ld_shift_c[7:0]};
            3'b001:  ld_val_c = {{16{ld_shift_c[15]}}, ld_shift_c[15:0]};
            3'b100:  ld_val_c = {24'd0, ld_shift_c[7:0]};
            3'b101:  ld_val_c = {16'd0, ld_shift_c[15:0]};
            default: ld_val_c = bus.mem_rdata;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        off_d       = off_q;
        funct3_d    = funct3_q;
        rd_d        = rd_q;
        rf_en_d     = 1'b0;
        rf_rd_d     = rf_rd_q;
        rf_wdata_d  = rf_wdata_q;
        misalign_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (bus.ex_mem_read || bus.ex_mem_write) begin
                        if (trap_c) begin
                            misalign_d = 1'b1;
                        end else begin
                            state_d     = WAIT;
                            mem_req_d   = 1'b1;
                            mem_we_d    = bus.ex_mem_write;
                            mem_addr_d  = {bus.ex_alu_result[XLEN-1:2], 2'b00};
                            mem_wdata_d = st_rep_c;
                            mem_wstrb_d = st_strb_c;
                            off_d       = eff_off_c;
                            funct3_d    = bus.ex_funct3;
                            rd_d        = bus.ex_rd;
                        end
                    end else if ((bus.ex_wb_sel != WB_NONE) && (bus.ex_rd != 5'd0)) begin
                        rf_en_d    = 1'b1;
                        rf_rd_d    = bus.ex_rd;
                        rf_wdata_d = (bus.ex_wb_sel == WB_PC4) ? (bus.ex_pc + 32'd4)
                                                               : bus.ex_alu_result;
                    end
                end
            end
            WAIT: begin
                if (bus.mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (!mem_we_q && (rd_q != 5'd0)) begin
                        rf_en_d    = 1'b1;
                        rf_rd_d    = rd_q;
                        rf_wdata_d = ld_val_c;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any outstanding request at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            off_q       <= '0;
            funct3_q    <= '0;
            rd_q        <= '0;
            rf_en_q     <= 1'b0;
            rf_rd_q     <= '0;
            rf_wdata_q  <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            off_q       <= off_d;
            funct3_q    <= funct3_d;
            rd_q        <= rd_d;
            rf_en_q     <= rf_en_d;
            rf_rd_q     <= rf_rd_d;
            rf_wdata_q  <= rf_wdata_d;
            misalign_q  <= misalign_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.rf_en     = rf_en_q;
    assign bus.rf_rd     = rf_rd_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.misalign  = misalign_q;

endmodule

// File: tb/tb_lsu_wb_stage.sv
// tb_lsu_wb_stage: directed vector table plus randomized instructions checked
// against a spec-level model of the writeback/memory behaviour.
module tb_lsu_wb_stage;

    logic clk;
    logic rst;
    lsu_wb_stage_if bus();

    lsu_wb_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // expected architectural write-port state (held between writes)
    logic [4:0]  last_rd;
    logic [31:0] last_wd;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic [1:0]  wb_sel;
        logic        mrd;
        logic        mwr;
        logic [2:0]  f3;
        logic [31:0] rdata;
        int          lat;
        logic        exp_mis;
        logic        exp_en;
        logic [31:0] exp_wb;
        logic [31:0] exp_addr;
        logic [31:0] exp_mwdata;
        logic [3:0]  exp_wstrb;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------- reference model (spec rules, plain arithmetic) ----------
    function automatic int lane_off(input logic [2:0] f3, input logic [31:0] a);
        if (f3[1:0] == 2'b00) return int'(a % 4);
        if (f3[1:0] == 2'b01) return (a % 4) >= 2 ? 2 : 0;
        return 0;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3[1:0] == 2'b00) return (d & 32'hFF) * 32'h0101_0101;
        if (f3[1:0] == 2'b01) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [31:0] a);
        int o;
        o = lane_off(f3, a);
        if (f3[1:0] == 2'b00) return 4'(1 << o);
        if (f3[1:0] == 2'b01) return 4'(3 << o);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
        logic [31:0] v;
        v = w / (32'd1 << (8 * lane_off(f3, a)));
        case (f3)
            3'b000: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            3'b001: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            3'b100: v = v % 256;
            3'b101: v = v % 65536;
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic m_trap(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
        if (f3[1:0] == 2'b01) return (a % 2) != 0;
        if (f3[1:0] != 2'b00) return (a % 4) != 0;
`endif
        return 1'b0;
    endfunction

    // Fill the expected-output fields of a vector from the model
    function automatic vec_t model(input vec_t v);
        vec_t r;
        r = v;
        r.exp_mis = (v.mrd || v.mwr) ? m_trap(v.f3, v.alu) : 1'b0;
        r.exp_addr   = v.alu - (v.alu % 4);
        r.exp_mwdata = m_wdata(v.f3, v.sd);
        r.exp_wstrb  = m_wstrb(v.f3, v.alu);
        if (v.mrd || v.mwr) begin
            r.exp_en = v.mrd && !r.exp_mis && (v.rd != 0);
            r.exp_wb = m_load(v.f3, v.alu, v.rdata);
        end else begin
            r.exp_en = (v.wb_sel != 2'b11) && (v.rd != 0);
            r.exp_wb = (v.wb_sel == 2'b10) ? v.pc + 32'd4 : v.alu;
        end
        return r;
    endfunction

    // Issue one instruction at a negedge (DUT idle) and check it to completion.
    // Returns at the negedge where writeback is visible, ready for the next issue.
    task automatic do_instr(input vec_t v, input string tag);
        chk({tag, ".ex_ready_issue"}, 32'(bus.ex_ready), 32'd1);
        bus.ex_valid      = 1'b1;
        bus.ex_alu_result = v.alu;
        bus.ex_pc         = v.pc;
        bus.ex_store_data = v.sd;
        bus.ex_rd         = v.rd;
        bus.ex_wb_sel     = v.wb_sel;
        bus.ex_mem_read   = v.mrd;
        bus.ex_mem_write  = v.mwr;
        bus.ex_funct3     = v.f3;
        bus.mem_ack       = 1'($urandom_range(0, 1));   // ignored while idle
        bus.mem_rdata     = $urandom;
        @(negedge clk);
        bus.ex_valid = 1'b0;
        bus.mem_ack  = 1'b0;
        if ((v.mrd || v.mwr) && !v.exp_mis) begin
            for (int c = 1; c <= v.lat; c++) begin
                chk({tag, ".mem_req"},   32'(bus.mem_req),  32'd1);
                chk({tag, ".ex_ready"},  32'(bus.ex_ready), 32'd0);
                chk({tag, ".mem_addr"},  bus.mem_addr,      v.exp_addr);
                chk({tag, ".mem_we"},    32'(bus.mem_we),   32'(v.mwr));
                chk({tag, ".rf_en_w"},   32'(bus.rf_en),    32'd0);
                if (v.mwr) begin
                    chk({tag, ".mem_wdata"}, bus.mem_wdata,      v.exp_mwdata);
                    chk({tag, ".mem_wstrb"}, 32'(bus.mem_wstrb), 32'(v.exp_wstrb));
                end
                if (c == v.lat) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = v.rdata;
                    bus.ex_valid  = 1'b0;
                end else begin
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = $urandom;
                    bus.ex_valid  = 1'($urandom_range(0, 1));  // must not be taken
                    bus.ex_mem_read = 1'b0;
                    bus.ex_mem_write = 1'b0;
                    bus.ex_wb_sel = 2'b00;
                    bus.ex_rd     = 5'd7;
                end
                @(negedge clk);
            end
            bus.mem_ack  = 1'b0;
            bus.ex_valid = 1'b0;
            chk({tag, ".ex_ready_done"}, 32'(bus.ex_ready), 32'd1);
        end
        chk({tag, ".mem_req_off"}, 32'(bus.mem_req),  32'd0);
        chk({tag, ".misalign"},    32'(bus.misalign), 32'(v.exp_mis));
        chk({tag, ".rf_en"},       32'(bus.rf_en),    32'(v.exp_en));
        if (v.exp_en) begin
            last_rd = v.rd;
            last_wd = v.exp_wb;
        end
        chk({tag, ".rf_rd"},    32'(bus.rf_rd), 32'(last_rd));
        chk({tag, ".rf_wdata"}, bus.rf_wdata,   last_wd);
    endtask

    task automatic mk(output vec_t v, input logic [31:0] alu, input logic [31:0] pc,
                      input logic [31:0] sd, input logic [4:0] rd, input logic [1:0] wb,
                      input logic mrd, input logic mwr, input logic [2:0] f3,
                      input logic [31:0] rdata, input int lat);
        v = '{alu: alu, pc: pc, sd: sd, rd: rd, wb_sel: wb, mrd: mrd, mwr: mwr, f3: f3,
              rdata: rdata, lat: lat, exp_mis: 1'b0, exp_en: 1'b0, exp_wb: 32'd0,
              exp_addr: 32'd0, exp_mwdata: 32'd0, exp_wstrb: 4'd0};
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        bus.ex_valid = 0; bus.ex_alu_result = 0; bus.ex_pc = 0; bus.ex_store_data = 0;
        bus.ex_rd = 0; bus.ex_wb_sel = 0; bus.ex_mem_read = 0; bus.ex_mem_write = 0;
        bus.ex_funct3 = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
        last_rd = 0; last_wd = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset.mem_req",  32'(bus.mem_req),  32'd0);
        chk("reset.rf_en",    32'(bus.rf_en),    32'd0);
        chk("reset.rf_wdata", bus.rf_wdata,      32'd0);
        chk("reset.mem_addr", bus.mem_addr,      32'd0);
        chk("reset.misalign", 32'(bus.misalign), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset.ex_ready", 32'(bus.ex_ready), 32'd1);

        // directed table: hand-derived expectations
        mk(v, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 2'b00, 0, 0, 3'b000, 0, 0);
        v.exp_en = 1; v.exp_wb = 32'h0000_1234; tbl.push_back(v);
        mk(v, 32'hDEAD_BEEF, 32'h100, 32'h0, 5'd1, 2'b10, 0, 0, 3'b000, 0, 0);
        v.exp_en = 1; v.exp_wb = 32'h0000_0104; tbl.push_back(v);
        mk(v, 32'h1111_1111, 32'h0, 32'h0, 5'd3, 2'b11, 0, 0, 3'b000, 0, 0);
        v.exp_en = 0; tbl.push_back(v);
        mk(v, 32'h2003, 32'h0, 32'h0, 5'd6, 2'b01, 1, 0, 3'b000, 32'h80FF_0000, 3);
        v.exp_en = 1; v.exp_wb = 32'hFFFF_FF80; v.exp_addr = 32'h2000; tbl.push_back(v);
        mk(v, 32'h2003, 32'h0, 32'h0, 5'd6, 2'b01, 1, 0, 3'b100, 32'h80FF_0000, 3);
        v.exp_en = 1; v.exp_wb = 32'h0000_0080; v.exp_addr = 32'h2000; tbl.push_back(v);
        mk(v, 32'h2002, 32'h0, 32'hABCD_1234, 5'd9, 2'b11, 0, 1, 3'b001, 0, 2);
        v.exp_en = 0; v.exp_addr = 32'h2000; v.exp_mwdata = 32'h1234_1234;
        v.exp_wstrb = 4'b1100; tbl.push_back(v);
        mk(v, 32'h3000, 32'h0, 32'h0, 5'd0, 2'b01, 1, 0, 3'b010, 32'h5555_AAAA, 1);
        v.exp_en = 0; v.exp_addr = 32'h3000; tbl.push_back(v);
        mk(v, 32'h2001, 32'h0, 32'h0, 5'd4, 2'b01, 1, 0, 3'b010, 32'hCAFE_F00D, 1);
`ifdef LSU_MISALIGN_TRAP_EN
        v.exp_mis = 1; v.exp_en = 0;
`else
        v.exp_en = 1; v.exp_wb = 32'hCAFE_F00D; v.exp_addr = 32'h2000;
`endif
        tbl.push_back(v);

        foreach (tbl[i]) do_instr(tbl[i], $sformatf("vec%0d", i));

        // reset in the middle of an outstanding access
        mk(v, 32'h4000, 32'h0, 32'h0, 5'd8, 2'b01, 1, 0, 3'b010, 0, 1);
        bus.ex_valid = 1; bus.ex_alu_result = v.alu; bus.ex_rd = v.rd;
        bus.ex_mem_read = 1; bus.ex_mem_write = 0; bus.ex_funct3 = v.f3;
        @(negedge clk);
        bus.ex_valid = 0;
        chk("rstmid.mem_req_before", 32'(bus.mem_req), 32'd1);
        #2 rst = 1'b1;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
        #1;
        chk("rstmid.mem_req", 32'(bus.mem_req), 32'd0);
        chk("rstmid.rf_en",   32'(bus.rf_en),   32'd0);
        @(negedge clk);
        bus.mem_ack = 1'b0;
        rst = 1'b0;
        last_rd = 0; last_wd = 0;
        @(negedge clk);
        chk("rstmid.ex_ready", 32'(bus.ex_ready), 32'd1);
        chk("rstmid.rf_en_after", 32'(bus.rf_en), 32'd0);
        chk("rstmid.rf_wdata", bus.rf_wdata, 32'd0);

        // randomized instructions against the model
        for (int n = 0; n < 300; n++) begin
            int kind;
            logic [2:0] f3s[5];
            f3s[0] = 3'b000; f3s[1] = 3'b001; f3s[2] = 3'b010; f3s[3] = 3'b100; f3s[4] = 3'b101;
            kind = $urandom_range(0, 3);
            mk(v, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
               2'($urandom_range(0, 3)), 0, 0, f3s[$urandom_range(0, 4)], $urandom,
               $urandom_range(1, 4));
            if (v.wb_sel == 2'b01) v.wb_sel = 2'b00;
            if (kind == 1) begin v.mrd = 1; v.wb_sel = 2'b01; end
            if (kind == 2) begin v.mwr = 1; v.wb_sel = 2'b11; if (v.f3[2]) v.f3[2] = 1'b0; end
            do_instr(model(v), $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
